// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU result write path.
package tpu_pkg;
  localparam int ARRAY_SIZE = 8;
  localparam int W          = 16;
  localparam int ACC_W      = 32;

  function automatic int num_diag(input int n);
    return 2 * n - 1;
  endfunction

  localparam int NUM_DIAG = num_diag(ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/tpu_lane_narrow.sv
// ACC_W -> W conversion for one output lane.
// Defining TPU_SKEW_SAT_EN selects signed saturation; otherwise plain truncation.
module tpu_lane_narrow
  import tpu_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = W
) (
  input  logic [IN_W-1:0]  acc,
  output logic [OUT_W-1:0] res
);
`ifdef TPU_SKEW_SAT_EN
  // In range only when every bit from the output sign bit upward agrees.
  logic [IN_W-OUT_W:0] hi;
  logic                fits;
  assign hi   = acc[IN_W-1:OUT_W-1];
  assign fits = (hi == '0) || (hi == '1);
  assign res  = fits       ? acc[OUT_W-1:0] :
                acc[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                              {1'b0, {(OUT_W-1){1'b1}}};
`else
  logic unused_hi;
  assign unused_hi = ^acc[IN_W-1:OUT_W];
  assign res       = acc[OUT_W-1:0];
`endif
endmodule

// File: rtl/tpu_result_skewer.sv
// Buffers the 8x8 accumulator result row by row and writes it out as 15 skewed
// diagonal words. Optional lane saturation: define TPU_SKEW_SAT_EN.
module tpu_result_skewer #(
  parameter int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
  parameter int W          = tpu_pkg::W,
  parameter int ACC_W      = tpu_pkg::ACC_W
) (
  input  logic                      clk,
  input  logic                      srstn,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ARRAY_SIZE*ACC_W-1:0] in_data,
  output logic                      sram_write_enable,
  output logic [5:0]                sram_waddr,
  output logic [ARRAY_SIZE*W-1:0]   sram_wdata,
  output logic                      done
);
  import tpu_pkg::*;

  localparam int N_DIAG = num_diag(ARRAY_SIZE);
  localparam int RW     = $clog2(ARRAY_SIZE + 1);
  localparam int EW     = $clog2(N_DIAG + 1);
  localparam int IW     = $clog2(ARRAY_SIZE);

  state_t        state, state_nx;
  logic [RW-1:0] rows_in, rows_nx, rows_eff, emin;
  logic [EW-1:0] e, e_nx;
  logic          accept, issue;

  // rbuf[row] keeps the row exactly as it arrived: column j sits at element ARRAY_SIZE-1-j.
  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][ACC_W-1:0] rbuf, rbuf_eff;
  logic [ARRAY_SIZE-1:0][ACC_W-1:0]                 diag_acc;
  logic [ARRAY_SIZE-1:0][W-1:0]                     diag_w;

  // The row being accepted is bypassed into the mux so diagonal r leaves on the same edge.
  always_comb begin
    accept   = (state == RUN) && in_valid && (rows_in < RW'(ARRAY_SIZE));
    rows_eff = rows_in + RW'(accept);
    emin     = (e >= EW'(ARRAY_SIZE - 1)) ? RW'(ARRAY_SIZE - 1) : RW'(e);
    issue    = (state == RUN) && (e <= EW'(N_DIAG - 1)) && (rows_eff > emin);
    rbuf_eff = rbuf;
    if (accept) rbuf_eff[rows_in[IW-1:0]] = in_data;
  end

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    logic [EW-1:0] j;
    assign j = e - EW'(k);
    assign diag_acc[k] = ((e >= EW'(k)) && (j < EW'(ARRAY_SIZE))) ?
                         rbuf_eff[k][IW'(ARRAY_SIZE - 1) - j[IW-1:0]] : '0;
    tpu_lane_narrow #(.IN_W(ACC_W), .OUT_W(W)) u_narrow (
      .acc (diag_acc[k]),
      .res (diag_w[ARRAY_SIZE-1-k])
    );
  end

  always_comb begin
    state_nx = state;
    rows_nx  = rows_in;
    e_nx     = e;
    case (state)
      IDLE: if (start) begin
        state_nx = RUN;
        rows_nx  = '0;
        e_nx     = '0;
      end
      RUN: begin
        if (accept) rows_nx = rows_in + RW'(1);
        if (issue) begin
          e_nx = e + EW'(1);
          if (e == EW'(N_DIAG - 1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state             <= IDLE;
      rows_in           <= '0;
      e                 <= '0;
      in_ready          <= 1'b0;
      sram_write_enable <= 1'b1;
      sram_waddr        <= '0;
      sram_wdata        <= '0;
      done              <= 1'b0;
    end else begin
      state             <= state_nx;
      rows_in           <= rows_nx;
      e                 <= e_nx;
      in_ready          <= (state_nx == RUN) && (rows_nx < RW'(ARRAY_SIZE));
      sram_write_enable <= !issue;
      if (issue) begin
        sram_waddr <= 6'(e);
        sram_wdata <= diag_w;
      end
      done              <= (state == DONE);
    end
  end

  // Data-only storage: never cleared, each run overwrites it row by row.
  always_ff @(posedge clk) begin
    if (accept) rbuf[rows_in[IW-1:0]] <= in_data;
  end
endmodule

// File: tb/tb_tpu_result_skewer.sv
// Directed bench for tpu_result_skewer: a scheduling model of the diagonal writes plus literal spot checks.
module tb_tpu_result_skewer;
  logic         clk = 1'b0;
  logic         srstn = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         sram_write_enable;
  logic [5:0]   sram_waddr;
  logic [127:0] sram_wdata;
  logic         done;

  tpu_result_skewer dut (
    .clk(clk), .srstn(srstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sram_write_enable(sram_write_enable), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- model ----------------
  logic [31:0]  M [8][8];
  logic [127:0] exp_word [int];
  int           exp_addr [int];
  bit           exp_done [int];
  int           cyc = 0;
  bit           m_busy = 0, m_ready = 0;
  int           m_rows = 0, m_end = -1;
  logic [5:0]   last_a = '0;
  logic [127:0] last_w = '0;

  function automatic logic [15:0] narrow(input logic [31:0] v);
`ifdef TPU_SKEW_SAT_EN
    if ($signed(v) > 32767)  return 16'h7FFF;
    if ($signed(v) < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic logic [127:0] diag_word(input int t);
    logic [127:0] w;
    int j;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      j = t - k;
      if (j >= 0 && j <= 7) w[(7-k)*16 +: 16] = narrow(M[k][j]);
    end
    return w;
  endfunction

  // Row r accepted at edge c puts diagonal r on the port after c; row 7 releases 8..14 one per edge.
  always @(posedge clk) begin
    cyc++;
    if (srstn) begin
      if (start && !m_busy) begin
        m_busy = 1; m_ready = 1; m_rows = 0; m_end = -1;
      end else if (m_busy && m_ready && in_valid) begin
        for (int j = 0; j < 8; j++) M[m_rows][j] = in_data[(7-j)*32 +: 32];
        exp_word[cyc] = diag_word(m_rows);
        exp_addr[cyc] = m_rows;
        if (m_rows == 7) begin
          for (int t = 8; t < tpu_pkg::NUM_DIAG; t++) begin
            exp_word[cyc+t-7] = diag_word(t);
            exp_addr[cyc+t-7] = t;
          end
          exp_done[cyc+8] = 1;
          m_end   = cyc + 8;
          m_ready = 0;
        end
        m_rows++;
      end
      if (m_busy && cyc == m_end) m_busy = 0;
    end
  end

  always @(negedge srstn) begin
    exp_word.delete(); exp_addr.delete(); exp_done.delete();
    m_busy = 0; m_ready = 0; last_a = '0; last_w = '0;
  end

  // ---------------- compare ----------------
  logic [127:0] cap_word [int];
  int           cap_cyc  [int];
  int           cap_cnt  [int];
  bit           done_seen = 0;
  int           done_cyc = 0;

  always @(negedge clk) begin
    if (!srstn) begin
      chk("rst_we", sram_write_enable, 1);
      chk("rst_addr", sram_waddr, 0);
      chk("rst_data", sram_wdata, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 0);
    end else begin
      chk("we", sram_write_enable, exp_word.exists(cyc) ? 1'b0 : 1'b1);
      if (exp_word.exists(cyc)) begin
        chk("waddr", sram_waddr, exp_addr[cyc]);
        chk("wdata", sram_wdata, exp_word[cyc]);
        last_a = 6'(exp_addr[cyc]);
        last_w = exp_word[cyc];
      end else begin
        chk("hold_addr", sram_waddr, last_a);
        chk("hold_data", sram_wdata, last_w);
      end
      chk("done", done, exp_done.exists(cyc) ? 1'b1 : 1'b0);
      chk("in_ready", in_ready, m_ready);
      if (!sram_write_enable) begin
        cap_word[int'(sram_waddr)] = sram_wdata;
        cap_cyc[int'(sram_waddr)]  = cyc;
        cap_cnt[int'(sram_waddr)]  = cap_cnt.exists(int'(sram_waddr)) ? cap_cnt[int'(sram_waddr)] + 1 : 1;
      end
      if (done) begin done_seen = 1; done_cyc = cyc; end
    end
  end

  // ---------------- stimulus ----------------
  logic [255:0] mat [8];

  task automatic load_count(input logic [31:0] base);
    for (int r = 0; r < 8; r++) begin
      mat[r] = '0;
      for (int j = 0; j < 8; j++) mat[r][(7-j)*32 +: 32] = base + 32'(16*r + j);
    end
  endtask

  task automatic clear_caps();
    cap_word.delete(); cap_cyc.delete(); cap_cnt.delete(); done_seen = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, sram_write_enable, 1);
    chk({tag, "_addr"}, sram_waddr, 0);
    chk({tag, "_data"}, sram_wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  task automatic chk_once(input string tag);
    for (int t = 0; t < 15; t++)
      chk({tag, "_once"}, cap_cnt.exists(t) ? cap_cnt[t] : 0, 1);
  endtask

  task automatic run_matrix(input int stall_after, input int stall_len, input bit poke, input bit extra);
    clear_caps();
    start = 1; @(negedge clk); start = 0;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1; in_data = mat[r]; start = poke && (r == 3);
      @(negedge clk); start = 0;
      if (r == stall_after) begin in_valid = 0; repeat (stall_len) @(negedge clk); end
    end
    if (extra) begin in_data = '1; @(negedge clk); end
    in_valid = 0;
    for (int i = 0; i < 40 && !done_seen; i++) @(negedge clk);
    chk("done_seen", done_seen, 1);
    repeat (2) @(negedge clk);
  endtask

  logic [127:0] tmp_w;
  logic [255:0] tmp_r;

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("init");
    #2 srstn = 1;

    // rows offered while idle are ignored
    clear_caps();
    @(negedge clk);
    in_valid = 1; in_data = {8{32'h1234_5678}};
    repeat (3) @(negedge clk);
    in_valid = 0;
    chk("idle_nowrite", cap_word.num(), 0);

    // identity, back-to-back, start poked mid-run, one surplus valid after row 7
    for (int r = 0; r < 8; r++) begin
      tmp_r = 256'd1; mat[r] = tmp_r << ((7-r)*32);
    end
    run_matrix(-1, 0, 1, 1);
    for (int t = 0; t < 15; t++) begin
      tmp_w = 128'd1;
      chk("id_word", cap_word.exists(t) ? cap_word[t] : 'x, (t % 2 == 0) ? (tmp_w << ((7 - t/2)*16)) : 128'd0);
    end
    chk_once("id");
    chk("id_span", cap_cyc[14] - cap_cyc[0], 14);
    chk("id_done", done_cyc - cap_cyc[14], 1);

    // C[k][j] = 16k+j
    load_count(32'h0);
    run_matrix(-1, 0, 0, 0);
    chk("model_d7", diag_word(7), 128'h0007_0016_0025_0034_0043_0052_0061_0070);
    chk("cnt_d7", cap_word[7], 128'h0007_0016_0025_0034_0043_0052_0061_0070);
    chk("cnt_d14", cap_word[14], 128'h77);
    chk("model_d14", diag_word(14), 128'h77);
    chk_once("cnt");

    // three stalled cycles after row 2
    load_count(32'h1000);
    run_matrix(2, 3, 0, 0);
    chk("stall_gap", cap_cyc[3] - cap_cyc[2], 4);
    chk("stall_pre", cap_cyc[2] - cap_cyc[0], 2);
    chk_once("stall");

    // narrowing of out-of-range accumulators
    load_count(32'hFFFF_FFC0);
    mat[0][255:192] = {32'h0001_2345, 32'hFFFF_0000};
    run_matrix(-1, 0, 0, 0);
    tmp_w = cap_word[0];
    tmp_r = {128'd0, cap_word[1]};
`ifdef TPU_SKEW_SAT_EN
    chk("sat_pos", tmp_w[127:112], 16'h7FFF);
    chk("sat_neg", tmp_r[127:112], 16'h8000);
`else
    chk("trunc_pos", tmp_w[127:112], 16'h2345);
    chk("trunc_neg", tmp_r[127:112], 16'h0000);
`endif

    // async reset after five diagonals, then a clean run
    for (int r = 0; r < 8; r++) mat[r] = {$urandom, $urandom, $urandom, $urandom,
                                          $urandom, $urandom, $urandom, $urandom};
    clear_caps();
    start = 1; @(negedge clk); start = 0;
    for (int r = 0; r < 5; r++) begin in_valid = 1; in_data = mat[r]; @(negedge clk); end
    in_valid = 0;
    #2 srstn = 0;
    #1 chk_reset("abort");
    chk("abort_writes", cap_word.num(), 5);
    @(negedge clk);
    #2 srstn = 1;
    load_count(32'h200);
    run_matrix(-1, 0, 0, 0);
    chk_once("fresh");
    chk("fresh_d14", cap_word[14], 128'h277);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
